fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter TRAP_VEC, 32'h0000_0100, the redirect target when trap_valid is asserted.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  pipeline control: decode cannot accept the presented instruction.
REQ-006 redirect_valid  input  1  branch/jump taken; redirect_pc is valid.
REQ-007 redirect_pc  input  32  branch/jump target.
REQ-008 trap_valid  input  1  exception/trap; fetch restarts at TRAP_VEC.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  request address; equals pc_out.
REQ-011 imem_gnt  input  1  memory accepted the request this cycle.
REQ-012 imem_rvalid  input  1  read data valid; arrives at least 1 cycle after gnt.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 if_valid  output  1  if_instr/if_pc hold a fetched instruction for decode.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 if_instr  output  32  fetched instruction.
REQ-017 pc_out  output  32  current PC register.

Function
REQ-018 FSM states: BOOT, REQ, WAIT, VALID; exactly one request outstanding at any time.
REQ-019 BOOT: imem_req=0; go to REQ on the next clock edge.
REQ-020 REQ: imem_req=1, imem_addr=pc_out; on imem_gnt go to WAIT, otherwise stay in REQ.
REQ-021 WAIT: imem_req=0; on imem_rvalid with kill=0, capture imem_rdata into if_instr, set if_valid=1 and go to VALID.
REQ-022 VALID: if_valid=1, if_pc=pc_out; with stall=0 the instruction is consumed, so pc_out<=pc_out+4 (modulo 2^32, wrapping FFFF_FFFC->0000_0000), if_valid<=0 and go to REQ; with stall=1 all outputs hold.
REQ-023 Redirect target: TRAP_VEC if trap_valid, else redirect_pc if redirect_valid; trap wins when both are asserted.
REQ-024 Redirect in REQ without gnt: pc_out<=target and stay in REQ; imem_addr may change before grant.
REQ-025 Redirect in REQ with gnt in the same cycle: go to WAIT, set kill=1 and pending<=target.
REQ-026 Redirect in WAIT without rvalid: set kill=1 and pending<=target; a later redirect overwrites pending.
REQ-027 imem_rvalid in WAIT with kill=1: discard the data, keep if_valid=0, pc_out<=pending, clear kill, go to REQ.
REQ-028 Redirect in the same cycle as imem_rvalid in WAIT: discard the data, pc_out<=target, clear kill, go to REQ.
REQ-029 Redirect in VALID: if_valid<=0, pc_out<=target, go to REQ; redirect overrides stall.
REQ-030 Redirect in BOOT: pc_out<=target before the first request.
REQ-031 stall has no effect in REQ or WAIT.
REQ-032 A fetch needs at least 3 cycles (REQ, WAIT, VALID) with zero-wait memory.

Reset
REQ-033 While reset=0: state=BOOT, pc_out=RESET_PC, imem_req=0, if_valid=0, if_pc=RESET_PC, if_instr=32'h0000_0013 (NOP), kill=0, pending=0.
REQ-034 Reset asserted mid-transaction abandons the request; any later imem_rvalid is ignored until the next grant.

Structure
REQ-035 Shared package holds the FSM state enum, the NOP constant 32'h0000_0013 and the default RESET_PC/TRAP_VEC values.
REQ-036 One sub-module is natural: pc_next_sel, a combinational priority mux for trap > redirect > pc+4 > hold.

Verification
REQ-037 Release reset with gnt and rvalid tied 1 and stall 0 -> imem_addr sequence 0x0, 0x4, 0x8; if_valid pulses once per 3 cycles.
REQ-038 stall=1 for 5 cycles in VALID -> if_instr, if_pc and pc_out are constant; the next imem_addr is if_pc+4 after stall drops.
REQ-039 Redirect to 0x200 in WAIT, then rvalid with 0xDEADBEEF -> data discarded, if_valid stays 0, next imem_addr=0x200.
REQ-040 trap_valid and redirect_valid (0x300) in the same cycle during VALID with stall=1 -> next imem_addr=0x100.
REQ-041 pc_out=0xFFFF_FFFC, consume the instruction -> next imem_addr=0x0000_0000.
REQ-042 Assert reset in WAIT, then deliver rvalid after release -> it is ignored; the first request goes to RESET_PC and outputs match REQ-033.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  // Fetch FSM: one memory request outstanding at any time.
  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_VALID = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request/response bus between fetch and memory.
interface fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Priority mux for the next PC: trap > redirect > sequential increment > hold.
module fetch_ctrl_pc_next_sel
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        trap_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inc_en,
  input  logic [31:0] pc_q,
  output logic        redir,
  output logic [31:0] target,
  output logic [31:0] pc_sel
);

  // Resolve the redirect target and the overall next-PC choice.
  always_comb begin
    redir = trap_valid | redirect_valid;
    if (trap_valid) begin
      target = TRAP_VEC;
    end else if (redirect_valid) begin
      target = redirect_pc;
    end else begin
      target = pc_q;
    end
    if (redir) begin
      pc_sel = target;
    end else if (inc_en) begin
      pc_sel = pc_q + INSTR_BYTES;  // wraps modulo 2^32
    end else begin
      pc_sel = pc_q;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding request, redirect/trap
// handling with kill of in-flight responses, and a stallable decode slot.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                trap_valid,
  fetch_ctrl_if.master        imem,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic [31:0]         pc_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_q, pending_d;
  logic         kill_q, kill_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         redir_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_sel_s;
  logic         inc_en_s;
  logic         imem_req_s;
  logic         if_valid_s;

  assign inc_en_s = (state_q == FS_VALID) && !stall;

  fetch_ctrl_pc_next_sel #(.TRAP_VEC(TRAP_VEC)) u_pc_next_sel (
    .trap_valid    (trap_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inc_en        (inc_en_s),
    .pc_q          (pc_q),
    .redir         (redir_s),
    .target        (target_s),
    .pc_sel        (pc_sel_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FS_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, kill/pending redirect, decode slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pending_q  <= 32'h0000_0000;
      kill_q     <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      kill_q     <= kill_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Next-state logic; a response in WAIT goes to decode only if not killed
  // or overtaken by a redirect in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_BOOT: state_d = FS_REQ;
      FS_REQ: begin
        if (imem.gnt) state_d = FS_WAIT;
        else          state_d = FS_REQ;
      end
      FS_WAIT: begin
        if (imem.rvalid) begin
          if (redir_s || kill_q) state_d = FS_REQ;
          else                   state_d = FS_VALID;
        end else begin
          state_d = FS_WAIT;
        end
      end
      FS_VALID: begin
        if (redir_s || !stall) state_d = FS_REQ;
        else                   state_d = FS_VALID;
      end
      default: state_d = FS_BOOT;
    endcase
  end

  // Datapath next values. A redirect that arrives while a request is in
  // flight is parked in pending and applied when the stale response returns.
  always_comb begin
    pc_d       = pc_q;
    pending_d  = pending_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      FS_BOOT: pc_d = pc_sel_s;
      FS_REQ: begin
        if (imem.gnt) begin
          if (redir_s) begin
            kill_d    = 1'b1;
            pending_d = target_s;
          end else begin
            kill_d    = 1'b0;
          end
        end else begin
          pc_d = pc_sel_s;  // address may move before grant
        end
      end
      FS_WAIT: begin
        if (imem.rvalid) begin
          kill_d = 1'b0;
          if (redir_s) begin
            pc_d = target_s;
          end else if (kill_q) begin
            pc_d = pending_q;
          end else begin
            if_instr_d = imem.rdata;
            if_pc_d    = pc_q;
          end
        end else if (redir_s) begin
          kill_d    = 1'b1;
          pending_d = target_s;
        end else begin
          kill_d    = kill_q;
        end
      end
      FS_VALID: pc_d = pc_sel_s;
      default: pc_d = pc_q;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    imem_req_s = 1'b0;
    if_valid_s = 1'b0;
    case (state_q)
      FS_REQ:   imem_req_s = 1'b1;
      FS_VALID: if_valid_s = 1'b1;
      default: begin
        imem_req_s = 1'b0;
        if_valid_s = 1'b0;
      end
    endcase
  end

  assign imem.req  = imem_req_s;
  assign imem.addr = pc_q;
  assign if_valid  = if_valid_s;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a PC-sequence reference model predicts
// each instruction handed to decode; a monitor compares on presentation.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0100;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        trap_valid = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr, pc_out;

  fetch_ctrl_if imem();

  fetch_ctrl #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .imem(imem),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int deliveries = 0;

  exp_t        exp_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] m_pc = RST_PC;
  bit          out_pend = 1'b0;
  logic [31:0] out_addr = 32'h0;
  int          mem_mode = 0;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0, man_rdata_en = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        s_valid, s_req;
  logic [31:0] s_addr, s_pc, s_instr, s_pcout;
  logic        prev_v = 1'b0;
  exp_t        cur_e = '0;
  logic [8:0]  vpat;
  logic [31:0] pc0;
  bit          ok;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_9617;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = memfn(pc);
    exp_q.delete();
    exp_q.push_back(e);
  endtask

  // One clock cycle: sample DUT, drive inputs and memory, advance the model.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc, input logic tr);
    logic g, r;
    @(negedge clk); #1;
    s_valid = if_valid; s_req = imem.req; s_addr = imem.addr;
    s_pc = if_pc; s_instr = if_instr; s_pcout = pc_out;
    case (mem_mode)
      0: begin g = 1'b1; r = 1'b1; end
      1: begin g = ($urandom_range(0, 1) == 1); r = out_pend && ($urandom_range(0, 2) != 0); end
      default: begin g = man_gnt; r = man_rvalid; end
    endcase
    imem.gnt = g;
    imem.rvalid = r;
    imem.rdata = (mem_mode == 2 && man_rdata_en) ? man_rdata : memfn(out_addr);
    stall = st; redirect_valid = rv; redirect_pc = rpc; trap_valid = tr;
    if (s_req) chk("one_outstanding", {31'd0, out_pend}, 32'd0);
    if (tr || rv) begin
      m_pc = tr ? TRAP_PC : rpc;
      push_exp(m_pc);
    end else if (s_valid && !st) begin
      m_pc = m_pc + 32'd4;
      push_exp(m_pc);
    end
    if (r && out_pend) out_pend = 1'b0;
    if (s_req && g) begin
      out_pend = 1'b1;
      out_addr = s_addr;
      gnt_log.push_back(s_addr);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0;
    m_pc = RST_PC;
    push_exp(RST_PC);
    out_pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("rst_pc_out", pc_out, RST_PC);
      chk("rst_req", {31'd0, imem.req}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_pc", if_pc, RST_PC);
      chk("rst_if_instr", if_instr, NOP);
    end
    reset = 1'b1;
  endtask

  task automatic wait_valid(input logic st_hold, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(st_hold, 1'b0, 32'd0, 1'b0);
      if (s_valid) got = 1'b1;
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL wait_valid: no if_valid within 40 cycles"); end
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      if (s_req) got = 1'b1;
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL wait_req: no imem_req within 40 cycles"); end
  endtask

  // Monitor: pop the expectation on each new presentation, hold-check after.
  initial begin
    forever begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: got delivery of pc %h, expected none", if_pc);
          end else begin
            cur_e = exp_q.pop_front();
            deliveries++;
          end
        end
        chk("sb_pc", if_pc, cur_e.pc);
        chk("sb_instr", if_instr, cur_e.instr);
      end
      prev_v = (if_valid === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;

    // Zero-wait memory: addresses 0,4,8 and one if_valid every 3 cycles.
    mem_mode = 0;
    do_reset(2);
    gnt_log.delete();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      vpat[i] = s_valid;
    end
    chk("t37_valid_pattern", {23'd0, vpat}, {23'd0, 9'b100100100});
    chk("t37_ngnt", 32'(gnt_log.size()), 32'd3);
    if (gnt_log.size() >= 3) begin
      chk("t37_addr0", gnt_log[0], 32'h0);
      chk("t37_addr1", gnt_log[1], 32'h4);
      chk("t37_addr2", gnt_log[2], 32'h8);
    end

    // Stall five cycles in VALID, then resume at if_pc+4.
    wait_valid(1'b1, ok);
    pc0 = m_pc;
    chk("t38_if_pc", s_pc, 32'hC);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("t38_pc_out_hold", s_pcout, pc0);
      chk("t38_valid_hold", {31'd0, s_valid}, 32'd1);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t38_req", {31'd0, s_req}, 32'd1);
    chk("t38_next_addr", s_addr, pc0 + 32'd4);

    // Redirect in WAIT, stale data arrives afterwards and must be dropped.
    mem_mode = 2; man_gnt = 1'b1; man_rvalid = 1'b1; man_rdata_en = 1'b0;
    wait_req(ok);
    man_rvalid = 1'b0;
    cycle(1'b0, 1'b1, 32'h200, 1'b0);
    chk("t39_valid_a", {31'd0, s_valid}, 32'd0);
    man_rvalid = 1'b1; man_rdata_en = 1'b1; man_rdata = 32'hDEAD_BEEF;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t39_valid_b", {31'd0, s_valid}, 32'd0);
    man_rvalid = 1'b0; man_rdata_en = 1'b0; man_gnt = 1'b0;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t39_valid_c", {31'd0, s_valid}, 32'd0);
    chk("t39_req", {31'd0, s_req}, 32'd1);
    chk("t39_addr", s_addr, 32'h200);
    man_gnt = 1'b1; man_rvalid = 1'b1;

    // Trap and redirect together while stalled in VALID: trap wins.
    mem_mode = 0;
    wait_valid(1'b1, ok);
    cycle(1'b1, 1'b1, 32'h300, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t40_req", {31'd0, s_req}, 32'd1);
    chk("t40_addr", s_addr, TRAP_PC);

    // PC wrap from FFFF_FFFC to 0.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_valid(1'b1, ok);
    chk("t41_if_pc", s_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t41_req", {31'd0, s_req}, 32'd1);
    chk("t41_wrap_addr", s_addr, 32'h0);

    // Reset while waiting; rvalid after release is ignored.
    mem_mode = 2; man_gnt = 1'b1; man_rvalid = 1'b1; man_rdata_en = 1'b0;
    wait_req(ok);
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata_en = 1'b1; man_rdata = 32'hDEAD_BEEF;
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("t42_req", {31'd0, s_req}, 32'd1);
      chk("t42_addr", s_addr, RST_PC);
      chk("t42_valid", {31'd0, s_valid}, 32'd0);
    end
    man_rdata_en = 1'b0; man_gnt = 1'b1;
    wait_valid(1'b1, ok);
    chk("t42_if_pc", s_pc, RST_PC);
    chk("t42_if_instr", s_instr, memfn(RST_PC));

    // Randomized traffic against the reference model.
    mem_mode = 1;
    for (int i = 0; i < 2500; i++) begin
      logic        st, rv, tr;
      logic [31:0] rpc;
      if (i == 1200) do_reset(1);
      st  = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 99) < 7);
      tr  = ($urandom_range(0, 99) < 3);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_FFFC);
      cycle(st, rv, rpc, tr);
    end
    chk("deliveries_min", {31'd0, deliveries > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
